// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Definitions shared by the PS/2 frame receiver and the make/break/extended
// key decoder that sits downstream of it.
//   rx_state_t     : receiver frame FSM states
//   PS2_EXT        : extended-key prefix byte
//   PS2_BRK        : break (key release) prefix byte
//   PS2_DATA_BITS  : payload bits per frame
//   odd_parity_ok  : odd-parity check over the payload plus parity bit
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam int         PS2_DATA_BITS = 8;

    // True when the nine bits (payload + parity) hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// -----------------------------------------------------------------------------
// ps2_frame_rx_if
// Received-byte bus from the PS/2 frame receiver to the key decoder.
//   data_out   : last correctly received byte
//   valid      : one-cycle strobe, data_out has just been updated
//   parity_err : one-cycle strobe, parity failed with a good stop bit
//   frame_err  : one-cycle strobe, bad start/stop bit or timeout
// master = receiver (drives), slave = decoder (observes).
// -----------------------------------------------------------------------------
interface ps2_frame_rx_if;

    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output data_out,
        output valid,
        output parity_err,
        output frame_err
    );

    modport slave (
        input data_out,
        input valid,
        input parity_err,
        input frame_err
    );

endinterface

// File: rtl/ps2_input_filter.sv
// -----------------------------------------------------------------------------
// ps2_input_filter
// Conditions one asynchronous PS/2 line: a 2-FF synchronizer followed by a
// run-length filter. The filtered level only moves to a new value once
// FILTER_LEN consecutive synchronized samples disagree with it; any shorter
// excursion is discarded. A registered one-cycle pulse marks each filtered
// 1->0 transition.
//   clk, reset : system clock, synchronous active-high reset
//   raw        : asynchronous pin
//   level      : filtered level (resets to 1, bus idle)
//   fall       : one-cycle pulse, coincident with level going 1->0
// -----------------------------------------------------------------------------
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          fall_q,  fall_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Next-state: synchronizer shift and run-length counter toward a new level.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // cnt_q counts disagreeing samples already seen; this one is the next.
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers; everything idles high so reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// -----------------------------------------------------------------------------
// ps2_frame_rx
// Receives PS/2 device-to-host frames (start, 8 data LSB first, odd parity,
// stop) sampled on filtered ps2_clk falling edges, and presents each good
// byte to the key decoder as a one-cycle valid strobe.
//   clk, reset : system clock, synchronous active-high reset
//   ps2_clk    : raw PS/2 clock pin (asynchronous)
//   ps2_data   : raw PS/2 data pin (asynchronous)
//   rx         : byte bus to the decoder (data_out, valid, parity_err,
//                frame_err), all registered
// A frame stalled for TIMEOUT_CYCLES clk cycles without a clock fall is
// abandoned with a frame_err pulse.
// -----------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_frame_rx_if.master rx
);

    localparam int TW = (TIMEOUT_CYCLES < 3) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic fall_s;
    logic data_s;
    logic clk_level_unused_s;
    logic data_fall_unused_s;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk),
        .level (clk_level_unused_s),
        .fall  (fall_s)
    );

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data),
        .level (data_s),
        .fall  (data_fall_unused_s)
    );

    rx_state_t   state_q,    state_d;
    logic [7:0]  shift_q,    shift_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic        par_q,      par_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q,    valid_d;
    logic        perr_q,     perr_d;
    logic        ferr_q,     ferr_d;
    logic        tmo_hit_s;

    assign tmo_hit_s = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM next-state. A fall in the same cycle as timeout expiry wins,
    // because the fall branch is tested first in every mid-frame state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        tmo_d      = '0;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_s) begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                        shift_d   = 8'h00;
                    end else begin
                        ferr_d    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (fall_s) begin
                    // LSB arrives first, so each new bit enters at the top.
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (tmo_hit_s) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            PARITY: begin
                if (fall_s) begin
                    par_d   = data_s;
                    state_d = STOP;
                end else if (tmo_hit_s) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            STOP: begin
                if (fall_s) begin
                    state_d = IDLE;
                    if (!data_s) begin
                        ferr_d = 1'b1;
                    end else if (!odd_parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame FSM and registered outputs; reset drops any partial frame silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx.data_out   = data_out_q;
    assign rx.valid      = valid_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;

endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
- Receives raw PS/2 device-to-host frames on the asynchronous `ps2_clk` and `ps2_data` lines.
- Validates each 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
- Presents each good byte as a one-cycle `valid` strobe with `data_out`.
- Sits directly upstream of the make/break/extended key decoder and drives that decoder's `valid` and `data_in` inputs.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required before the filtered `ps2_clk`/`ps2_data` level changes.
- TIMEOUT_CYCLES, 10000: `clk` cycles without a filtered `ps2_clk` falling edge, while mid-frame, before the frame is aborted (200 us at 50 MHz).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin; asynchronous.
- ps2_data  input  1  raw PS/2 data pin; asynchronous.
- data_out  output  8  last correctly received byte.
- valid  output  1  one-cycle pulse when `data_out` has just been updated.
- parity_err  output  1  one-cycle pulse: frame had a parity error and a good stop bit.
- frame_err  output  1  one-cycle pulse: bad start/stop bit or timeout.

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset is synchronous, active-high, and sampled on the rising edge of `clk`.
  - Reset values: `data_out`=8'h00, `valid`=0, `parity_err`=0, `frame_err`=0.
  - Reset also clears the FSM to IDLE, the shift register, `bit_cnt`, the timeout counter and the filter state. The filtered levels reset to 1 (bus idle high).
  - Reset mid-frame discards the partial frame with no error pulse.
- Input conditioning:
  - Each pin goes through a 2-FF synchronizer, then the FILTER_LEN majority-free run filter.
  - The filtered level changes only after FILTER_LEN equal samples.
  - `fall` is a one-cycle pulse when filtered `ps2_clk` goes 1->0.
  - All data sampling uses the filtered `ps2_data` in the same cycle that `fall` is high.
- FSM states (shared enum): IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if data=0, go to DATA with `bit_cnt`=0 and shift register cleared. If data=1, stay in IDLE and pulse `frame_err`.
  - DATA: on `fall`, shift right with data entering bit 7 (LSB-first reception). When `bit_cnt`=7, go to PARITY; otherwise increment `bit_cnt`.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, go to IDLE and evaluate the frame:
    - stop=0: `frame_err`=1 only.
    - stop=1 and odd parity fails (XOR of 8 data bits and parity bit != 1): `parity_err`=1.
    - Otherwise: `data_out`<=byte and `valid`=1.
- Latency: outputs assert in the cycle after the `clk` edge on which the stop-bit `fall` is seen. That is 1 cycle after `fall`, and 2 + FILTER_LEN + 1 cycles after the raw pin edge.
- Pulses: each of `valid`, `parity_err` and `frame_err` lasts exactly one cycle. At most one of them is high per cycle.
- `data_out` holds its value between good frames and on all errors.
- Timeout:
  - The counter runs in DATA, PARITY and STOP, and clears on every `fall`.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and `frame_err` pulses.
  - The counter is held at 0 in IDLE.
- Simultaneous events: reset wins over everything. A timeout expiring in the same cycle as `fall` is treated as the `fall` (no timeout).
- No host-to-device transmission; the pins are input-only.

Decomposition:
- Package ps2_pkg:
  - `rx_state_t` enum (IDLE, DATA, PARITY, STOP).
  - Protocol constants shared with the downstream decoder: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_DATA_BITS=8.
- Sub-module ps2_input_filter: 2-FF synchronizer, run-length filter and falling-edge detector for one line, parameterized by FILTER_LEN. Two instances: one for the clock (with `fall` output), one for data (level only).
- Top level holds the FSM, shift register, `bit_cnt`, parity check and timeout counter.

Test Plan:
- Good frame: 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), 40 us half-periods -> one `valid` pulse, `data_out`=8'h1C, no error pulses.
- Parity error: 0x1C with parity=1 -> `parity_err` single pulse, `valid`=0, `data_out` keeps the prior value 8'h1C. Then a good 0xF0 frame (parity 1) -> `valid`, `data_out`=8'hF0.
- Stop error: 0x1C frame with stop=0 -> `frame_err` pulse only, `data_out` unchanged, FSM back in IDLE.
- Timeout: start bit + 4 data bits, then `ps2_clk` held high for TIMEOUT_CYCLES+10 cycles -> exactly one `frame_err` pulse. Then a full 0xE0 frame (parity 0) -> `valid`, `data_out`=8'hE0.
- Reset mid-frame: after 5 data bits, assert `reset` for 1 cycle -> all outputs 0, no error pulse. Next 0x1C frame is received correctly.
- Glitch rejection: `ps2_clk` low for FILTER_LEN-1 cycles inside a bit period of a 0x1C frame -> no extra shift, `data_out`=8'h1C, no errors.
